// File: rtl/shoal_am_pkg.sv
// Shared definitions for the Shoal active-message receive path: AM header
// field positions, error-code bit positions and the strip_id FSM state type.
package shoal_am_pkg;

    localparam int AM_DST_LSB = 24;
    localparam int AM_DST_MSB = 39;
    localparam int AM_DST_W   = AM_DST_MSB - AM_DST_LSB + 1;

    localparam int ERR_SHORT  = 0;
    localparam int ERR_LONG   = 1;
    localparam int ERR_DST    = 2;
    localparam int ERR_W      = 3;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } strip_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry registered AXIS stage: full-throughput when downstream is ready,
// holds its beat stable while stalled. Payload registers carry no reset.
module axis_reg_slice #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 16,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [TDATA_WIDTH-1:0] s_data,
    input  logic [TDEST_WIDTH-1:0] s_dest,
    input  logic [TKEEP_WIDTH-1:0] s_keep,
    input  logic                   s_last,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [TDATA_WIDTH-1:0] m_data,
    output logic [TDEST_WIDTH-1:0] m_dest,
    output logic [TKEEP_WIDTH-1:0] m_keep,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready
);

    logic                   vld_p1;
    logic [TDATA_WIDTH-1:0] data_p1;
    logic [TDEST_WIDTH-1:0] dest_p1;
    logic [TKEEP_WIDTH-1:0] keep_p1;
    logic                   last_p1;

    assign s_ready = !vld_p1 || m_ready;

    // ---- stage p1: output register ----
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_p1 <= 1'b0;
        end else if (s_ready) begin
            vld_p1 <= s_valid;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (s_valid && s_ready) begin
            data_p1 <= s_data;
            dest_p1 <= s_dest;
            keep_p1 <= s_keep;
            last_p1 <= s_last;
        end
    end

    assign m_valid = vld_p1;
    assign m_data  = data_p1;
    assign m_dest  = dest_p1;
    assign m_keep  = keep_p1;
    assign m_last  = last_p1;

endmodule

// File: rtl/strip_id.sv
// Receive-side AXIS stage: checks TID/TUSER against each packet, truncates at the
// declared length, strips the sidebands. Optional counters under STRIP_ID_STATS_EN.
module strip_id
    import shoal_am_pkg::*;
#(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 16,
    parameter int TID_WIDTH   = 16,
    parameter int TUSER_WIDTH = 16,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [TDATA_WIDTH-1:0] in_TDATA,
    input  logic                   in_TVALID,
    output logic                   in_TREADY,
    input  logic [TDEST_WIDTH-1:0] in_TDEST,
    input  logic                   in_TLAST,
    input  logic [TKEEP_WIDTH-1:0] in_TKEEP,
    input  logic [TID_WIDTH-1:0]   in_TID,
    input  logic [TUSER_WIDTH-1:0] in_TUSER,
    output logic [TDATA_WIDTH-1:0] out_TDATA,
    output logic                   out_TVALID,
    input  logic                   out_TREADY,
    output logic [TDEST_WIDTH-1:0] out_TDEST,
    output logic                   out_TLAST,
    output logic [TKEEP_WIDTH-1:0] out_TKEEP,
    output logic                   err_valid,
    output logic [ERR_W-1:0]       err_code,
    output logic [TID_WIDTH-1:0]   err_tid
`ifdef STRIP_ID_STATS_EN
    ,
    output logic [31:0]            pkt_count,
    output logic [31:0]            err_count
`endif
);

    // A declared length of zero still carries the header beat.
    function automatic logic [TUSER_WIDTH-1:0] norm_len(input logic [TUSER_WIDTH-1:0] len);
        return (len == '0) ? TUSER_WIDTH'(1) : len;
    endfunction

    function automatic logic [TUSER_WIDTH-1:0] sat_inc(input logic [TUSER_WIDTH-1:0] cnt,
                                                       input logic [TUSER_WIDTH-1:0] lim);
        return (cnt >= lim) ? lim : cnt + TUSER_WIDTH'(1);
    endfunction

    strip_state_t           state_p0;
    logic [TUSER_WIDTH-1:0] exp_len_p0;
    logic [TUSER_WIDTH-1:0] count_p0;
    logic [TID_WIDTH-1:0]   tid_p0;

    logic                   slice_ready;
    logic                   is_hdr;
    logic                   is_drop;
    logic                   acc;
    logic                   fwd;
    logic [TUSER_WIDTH-1:0] cur_len;
    logic [TUSER_WIDTH-1:0] cur_cnt;
    logic [TID_WIDTH-1:0]   cur_tid;
    logic                   at_end;
    logic                   err_dst;
    logic                   err_long;
    logic                   err_short;
    logic [ERR_W-1:0]       code;
    logic                   fwd_last;

    // ---- stage p0: header/length check on the accepted input beat ----
    always_comb begin
        is_hdr    = (state_p0 == HDR);
        is_drop   = (state_p0 == DROP);
        in_TREADY = is_drop || slice_ready;
        acc       = in_TVALID && in_TREADY;
        fwd       = acc && !is_drop;
        cur_len   = is_hdr ? norm_len(in_TUSER) : exp_len_p0;
        cur_cnt   = is_hdr ? TUSER_WIDTH'(1) : count_p0;
        cur_tid   = is_hdr ? in_TID : tid_p0;
        at_end    = (cur_cnt >= cur_len);
        err_dst   = is_hdr && (TID_WIDTH'(in_TDATA[AM_DST_MSB:AM_DST_LSB]) != in_TID);
        err_long  = at_end && !in_TLAST;
        err_short = !at_end && in_TLAST;
        fwd_last  = at_end || in_TLAST;
        code             = '0;
        code[ERR_SHORT]  = err_short;
        code[ERR_LONG]   = err_long;
        code[ERR_DST]    = err_dst;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_p0   <= HDR;
            exp_len_p0 <= '0;
            count_p0   <= '0;
            tid_p0     <= '0;
        end else if (acc) begin
            if (is_drop) begin
                if (in_TLAST) state_p0 <= HDR;
            end else begin
                exp_len_p0 <= cur_len;
                tid_p0     <= cur_tid;
                if (err_long) begin
                    state_p0 <= DROP;
                    count_p0 <= cur_cnt;
                end else if (fwd_last) begin
                    state_p0 <= HDR;
                    count_p0 <= cur_cnt;
                end else begin
                    state_p0 <= BODY;
                    count_p0 <= sat_inc(cur_cnt, cur_len);
                end
            end
        end
    end

    // ---- stage p1: error strobe, aligned with the forwarded beat ----
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_valid <= 1'b0;
            err_code  <= '0;
            err_tid   <= '0;
        end else begin
            err_valid <= fwd && (code != '0);
            if (fwd && (code != '0)) begin
                err_code <= code;
                err_tid  <= cur_tid;
            end
        end
    end

    axis_reg_slice #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .TDEST_WIDTH (TDEST_WIDTH),
        .TKEEP_WIDTH (TKEEP_WIDTH)
    ) u_out_slice (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_data   (in_TDATA),
        .s_dest   (in_TDEST),
        .s_keep   (in_TKEEP),
        .s_last   (fwd_last),
        .s_valid  (in_TVALID && !is_drop),
        .s_ready  (slice_ready),
        .m_data   (out_TDATA),
        .m_dest   (out_TDEST),
        .m_keep   (out_TKEEP),
        .m_last   (out_TLAST),
        .m_valid  (out_TVALID),
        .m_ready  (out_TREADY)
    );

`ifdef STRIP_ID_STATS_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            if (out_TVALID && out_TREADY && out_TLAST) pkt_count <= pkt_count + 32'd1;
            if (err_valid) err_count <= err_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_strip_id.sv
// Directed bench for strip_id: packet table with hand-computed outputs/errors,
// plus stall, random-backpressure and mid-packet reset sequences.
module tb_strip_id;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [63:0] in_TDATA;
    logic        in_TVALID;
    logic        in_TREADY;
    logic [15:0] in_TDEST;
    logic        in_TLAST;
    logic [7:0]  in_TKEEP;
    logic [15:0] in_TID;
    logic [15:0] in_TUSER;
    logic [63:0] out_TDATA;
    logic        out_TVALID;
    logic        out_TREADY;
    logic [15:0] out_TDEST;
    logic        out_TLAST;
    logic [7:0]  out_TKEEP;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] err_tid;
`ifdef STRIP_ID_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] err_count;
`endif

    strip_id dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TREADY  (in_TREADY),
        .in_TDEST   (in_TDEST),
        .in_TLAST   (in_TLAST),
        .in_TKEEP   (in_TKEEP),
        .in_TID     (in_TID),
        .in_TUSER   (in_TUSER),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TREADY (out_TREADY),
        .out_TDEST  (out_TDEST),
        .out_TLAST  (out_TLAST),
        .out_TKEEP  (out_TKEEP),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_tid    (err_tid)
`ifdef STRIP_ID_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .err_count  (err_count)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [15:0] dest;
    } beat_t;

    typedef struct {
        int          n;
        logic [15:0] tuser;
        logic [15:0] tid;
        logic [15:0] dst;
        int          nout;
        int          nerr;
        logic [2:0]  e0;
        logic [2:0]  e1;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    beat_t      out_q[$];
    beat_t      exp_q[$];
    logic [2:0] errc_q[$];
    logic [15:0] errt_q[$];

    logic        stall_prev = 1'b0;
    logic [63:0] stall_data;
    bit          rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] pid, input int i, input logic [15:0] dst);
        logic [63:0] d;
        d        = '0;
        d[63:56] = pid;
        d[55:48] = 8'(i);
        d[39:24] = (i == 0) ? dst : 16'hBEEF;
        d[23:0]  = 24'(i) + 24'h100;
        return d;
    endfunction

    // Output and error monitor, sampled on the falling edge.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (stall_prev) begin
                check("stall_valid_held", 64'(out_TVALID), 64'd1);
                check("stall_data_held", out_TDATA, stall_data);
            end
            if (out_TVALID && out_TREADY)
                out_q.push_back('{data: out_TDATA, last: out_TLAST, dest: out_TDEST});
            if (err_valid) begin
                errc_q.push_back(err_code);
                errt_q.push_back(err_tid);
            end
            stall_prev = out_TVALID && !out_TREADY;
            stall_data = out_TDATA;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic wait_accept();
        int k;
        k = 0;
        forever begin
            @(negedge ap_clk);
            if (in_TREADY) break;
            k++;
            if (k > 1000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: in_TREADY stuck 0 after %0d cycles", k);
                break;
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    // Sends the first nsend beats of an n-beat packet. Sidebands are garbage on
    // body beats since only the header beat's TID/TUSER may be used.
    task automatic send(input logic [7:0] pid, input int n, input int nsend,
                        input logic [15:0] tuser, input logic [15:0] tid, input logic [15:0] dst);
        for (int i = 0; i < nsend; i++) begin
            in_TDATA  = mk(pid, i, dst);
            in_TLAST  = (i == n - 1);
            in_TVALID = 1'b1;
            in_TDEST  = {8'h0, pid};
            in_TKEEP  = 8'hFF;
            in_TID    = (i == 0) ? tid : ~tid;
            in_TUSER  = (i == 0) ? tuser : tuser + 16'd7;
            wait_accept();
        end
        in_TVALID = 1'b0;
        in_TLAST  = 1'b0;
    endtask

    task automatic clear_q();
        out_q.delete();
        errc_q.delete();
        errt_q.delete();
    endtask

    vec_t vecs[11];

    initial begin
        int k;
        int bad;
        vecs[0]  = '{n:4, tuser:16'd4, tid:16'h0012, dst:16'h0012, nout:4, nerr:0, e0:3'b000, e1:3'b000};
        vecs[1]  = '{n:6, tuser:16'd4, tid:16'h0033, dst:16'h0033, nout:4, nerr:1, e0:3'b010, e1:3'b000};
        vecs[2]  = '{n:2, tuser:16'd5, tid:16'h0044, dst:16'h0044, nout:2, nerr:1, e0:3'b001, e1:3'b000};
        vecs[3]  = '{n:1, tuser:16'd0, tid:16'h0002, dst:16'h0001, nout:1, nerr:1, e0:3'b100, e1:3'b000};
        vecs[4]  = '{n:3, tuser:16'd3, tid:16'h1234, dst:16'h1234, nout:3, nerr:0, e0:3'b000, e1:3'b000};
        vecs[5]  = '{n:1, tuser:16'd1, tid:16'h0007, dst:16'h0070, nout:1, nerr:1, e0:3'b100, e1:3'b000};
        vecs[6]  = '{n:3, tuser:16'd1, tid:16'h0006, dst:16'h0005, nout:1, nerr:1, e0:3'b110, e1:3'b000};
        vecs[7]  = '{n:3, tuser:16'd5, tid:16'h00A1, dst:16'h00B2, nout:3, nerr:2, e0:3'b100, e1:3'b001};
        vecs[8]  = '{n:5, tuser:16'd3, tid:16'h0C0C, dst:16'h0D0D, nout:3, nerr:2, e0:3'b100, e1:3'b010};
        vecs[9]  = '{n:1, tuser:16'd3, tid:16'h0099, dst:16'h0099, nout:1, nerr:1, e0:3'b001, e1:3'b000};
        vecs[10] = '{n:2, tuser:16'd0, tid:16'h0055, dst:16'h0055, nout:1, nerr:1, e0:3'b010, e1:3'b000};

        ap_rst_n   = 1'b0;
        in_TDATA   = '0;
        in_TVALID  = 1'b0;
        in_TDEST   = '0;
        in_TLAST   = 1'b0;
        in_TKEEP   = '0;
        in_TID     = '0;
        in_TUSER   = '0;
        out_TREADY = 1'b1;

        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_out_valid", 64'(out_TVALID), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_err_tid", 64'(err_tid), 64'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("idle_in_ready", 64'(in_TREADY), 64'd1);

        // Table of packets, full-rate output.
        for (int v = 0; v < 11; v++) begin
            clear_q();
            send(8'(v + 1), vecs[v].n, vecs[v].n, vecs[v].tuser, vecs[v].tid, vecs[v].dst);
            repeat (4) @(posedge ap_clk);
            #1;
            check($sformatf("v%0d_nout", v), 64'(out_q.size()), 64'(vecs[v].nout));
            for (int j = 0; j < out_q.size() && j < vecs[v].nout; j++) begin
                check($sformatf("v%0d_b%0d_data", v, j), out_q[j].data, mk(8'(v + 1), j, vecs[v].dst));
                check($sformatf("v%0d_b%0d_last", v, j), 64'(out_q[j].last), 64'(j == vecs[v].nout - 1));
            end
            check($sformatf("v%0d_nerr", v), 64'(errc_q.size()), 64'(vecs[v].nerr));
            if (errc_q.size() >= 1 && vecs[v].nerr >= 1) begin
                check($sformatf("v%0d_err0", v), 64'(errc_q[0]), 64'(vecs[v].e0));
                check($sformatf("v%0d_tid0", v), 64'(errt_q[0]), 64'(vecs[v].tid));
            end
            if (errc_q.size() >= 2 && vecs[v].nerr >= 2) begin
                check($sformatf("v%0d_err1", v), 64'(errc_q[1]), 64'(vecs[v].e1));
                check($sformatf("v%0d_tid1", v), 64'(errt_q[1]), 64'(vecs[v].tid));
            end
        end

        // Stalled output: slice full blocks input, beat held stable.
        clear_q();
        out_TREADY = 1'b0;
        in_TDATA   = mk(8'h40, 0, 16'h0021);
        in_TLAST   = 1'b0;
        in_TVALID  = 1'b1;
        in_TDEST   = 16'h0040;
        in_TKEEP   = 8'hFF;
        in_TID     = 16'h0021;
        in_TUSER   = 16'd2;
        wait_accept();
        in_TDATA = mk(8'h40, 1, 16'h0021);
        in_TLAST = 1'b1;
        in_TID   = 16'hFFFF;
        repeat (3) @(posedge ap_clk);
        #1;
        check("stall_out_valid", 64'(out_TVALID), 64'd1);
        check("stall_in_ready", 64'(in_TREADY), 64'd0);
        check("stall_out_data", out_TDATA, mk(8'h40, 0, 16'h0021));
        out_TREADY = 1'b1;
        wait_accept();
        in_TVALID = 1'b0;
        in_TLAST  = 1'b0;
        repeat (4) @(posedge ap_clk);
        #1;
        check("stall_nout", 64'(out_q.size()), 64'd2);
        check("stall_nerr", 64'(errc_q.size()), 64'd0);

        // Random backpressure over 100 well-formed packets.
        clear_q();
        exp_q.delete();
        rand_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 100; p++) begin
                    int          n;
                    logic [15:0] t;
                    n = int'($urandom_range(1, 5));
                    t = 16'($urandom);
                    for (int i = 0; i < n; i++)
                        exp_q.push_back('{data: mk(8'(p), i, t), last: (i == n - 1), dest: 16'(p & 255)});
                    send(8'(p), n, n, 16'(n), t, t);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge ap_clk);
                    #1;
                    out_TREADY = 1'($urandom_range(0, 1));
                end
            end
        join
        out_TREADY = 1'b1;
        k = 0;
        while (out_q.size() < exp_q.size() && k < 500) begin
            @(posedge ap_clk);
            k++;
        end
        repeat (2) @(posedge ap_clk);
        #1;
        check("rand_nbeats", 64'(out_q.size()), 64'(exp_q.size()));
        bad = 0;
        for (int j = 0; j < out_q.size() && j < exp_q.size(); j++)
            if (out_q[j].data !== exp_q[j].data || out_q[j].last !== exp_q[j].last ||
                out_q[j].dest !== exp_q[j].dest)
                bad++;
        check("rand_beat_errors", 64'(bad), 64'd0);
        check("rand_nerr", 64'(errc_q.size()), 64'd0);

        // Reset mid-packet: output cleared at once, next beat is a header.
        clear_q();
        send(8'h70, 4, 2, 16'd4, 16'h0abc, 16'h0abc);
        ap_rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_TVALID), 64'd0);
        check("midrst_err_valid", 64'(err_valid), 64'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        clear_q();
        @(posedge ap_clk);
        #1;
        send(8'h71, 3, 3, 16'd3, 16'h0def, 16'h0def);
        repeat (4) @(posedge ap_clk);
        #1;
        check("postrst_nout", 64'(out_q.size()), 64'd3);
        if (out_q.size() == 3) begin
            check("postrst_b0", out_q[0].data, mk(8'h71, 0, 16'h0def));
            check("postrst_last", 64'(out_q[2].last), 64'd1);
        end
        check("postrst_nerr", 64'(errc_q.size()), 64'd0);
`ifdef STRIP_ID_STATS_EN
        check("stats_pkt_count", 64'(pkt_count), 64'd1);
        check("stats_err_count", 64'(err_count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
